// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's load/store path and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_func3, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_func3, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, programmable latency, RV32I widths,
// registered one-cycle response with fault flag.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [2:0]  LatM1 = 3'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StCommit} state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            write_q;
    logic [31:0]     addr_q, wdata_q;
    logic [2:0]      func3_q;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_error_q, rsp_error_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic [31:0]     mem [Depth];

    logic                  accept;
    logic                  fault;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           cur_word, load_data, new_word, lane_data;
    logic [3:0]            lane_mask;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign accept   = bus.req_valid && (state_q == StIdle);
    assign idx      = addr_q[ADDR_WIDTH+1:2];
    assign cur_word = mem[idx];
    assign byte_sel = cur_word[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? cur_word[31:16] : cur_word[15:0];

    always_comb begin
        case (func3_q)
            3'b000, 3'b100: fault = 1'b0;
            3'b001, 3'b101: fault = addr_q[0];
            3'b010:         fault = |addr_q[1:0];
            default:        fault = 1'b1;
        endcase
        if (write_q && func3_q[2]) fault = 1'b1;
        if (addr_q[31:ADDR_WIDTH+2] != '0) fault = 1'b1;
    end

    // func3[2] selects zero extension for the narrow loads
    always_comb begin
        case (func3_q[1:0])
            2'b00:   load_data = {{24{byte_sel[7] & ~func3_q[2]}}, byte_sel};
            2'b01:   load_data = {{16{half_sel[15] & ~func3_q[2]}}, half_sel};
            default: load_data = cur_word;
        endcase
    end

    // Replicate store data into every lane, then keep only the selected bytes
    always_comb begin
        case (func3_q[1:0])
            2'b00: begin
                lane_data = {4{wdata_q[7:0]}};
                lane_mask = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                lane_data = {2{wdata_q[15:0]}};
                lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_data = wdata_q;
                lane_mask = 4'b1111;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            new_word[8*i +: 8] = lane_mask[i] ? lane_data[8*i +: 8] : cur_word[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = LatM1;
                    state_d = (LatM1 == 3'd0) ? StCommit : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = StCommit;
            end
            StCommit: begin
                rsp_valid_d = 1'b1;
                rsp_error_d = fault;
                rsp_rdata_d = (fault || write_q) ? 32'h0 : load_data;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            func3_q     <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                func3_q <= bus.req_func3;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    // Storage is deliberately not reset; state_q drops out of StCommit on reset
    assign mem_we = (state_q == StCommit) && write_q && !fault;

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= new_word;
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboarded loads/stores, faults, streaming and reset abort.
module tb_dmem_responder;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    logic prev_valid;
    exp_t sb_q[$];

    dmem_responder_if bus ();
    dmem_responder_if bus3 ();

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every pulse
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rsp_valid) begin
                chk("pulse_width", 32'(prev_valid), 32'h0);
                chk("rsp_expected", 32'(sb_q.size() != 0), 32'h1);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rdata", bus.rsp_rdata, e.rdata);
                    chk("error", 32'(bus.rsp_error), 32'(e.err));
                    chk("latency", 32'(cyc), 32'(e.due));
                    chk("ready_with_rsp", 32'(bus.req_ready), 32'h1);
                end
            end
            prev_valid = bus.rsp_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_func3 = f3;
        bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 32'(bus.req_ready), 32'h1);
        sb_q.push_back('{er, ee, cyc + 1 + LAT});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 32'h1);
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", 32'(sb_q.size()), 32'h0);
        sb_q.delete();
    endtask

    initial begin
        int   last_acc;
        int   n_acc;
        logic prev3;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_func3  = '0;
        bus.req_wdata  = '0;
        bus3.req_valid = 1'b0;
        bus3.req_write = 1'b1;
        bus3.req_addr  = 32'h40;
        bus3.req_func3 = 3'b010;
        bus3.req_wdata = 32'h0;

        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_error", 32'(bus.rsp_error), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Word store/load round trip
        do_req(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req(1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte and half lanes, sign and zero extension
        do_req(1'b1, 32'h20, 3'b010, 32'h11223344, 32'h0, 1'b0);
        do_req(1'b1, 32'h21, 3'b000, 32'h00000080, 32'h0, 1'b0);
        do_req(1'b0, 32'h21, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req(1'b0, 32'h21, 3'b100, 32'h0, 32'h00000080, 1'b0);
        do_req(1'b0, 32'h20, 3'b010, 32'h0, 32'h11228044, 1'b0);
        do_req(1'b0, 32'h20, 3'b000, 32'h0, 32'h00000044, 1'b0);
        do_req(1'b0, 32'h22, 3'b001, 32'h0, 32'h00001122, 1'b0);
        do_req(1'b1, 32'h22, 3'b001, 32'h1234BEEF, 32'h0, 1'b0);
        do_req(1'b0, 32'h22, 3'b001, 32'h0, 32'hFFFFBEEF, 1'b0);
        do_req(1'b0, 32'h22, 3'b101, 32'h0, 32'h0000BEEF, 1'b0);
        do_req(1'b0, 32'h20, 3'b010, 32'h0, 32'hBEEF8044, 1'b0);

        // Faults: misaligned, out of range, illegal widths; memory untouched
        do_req(1'b0, 32'h12, 3'b010, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 32'h13, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req(1'b0, 32'h00001000, 3'b010, 32'h0, 32'h0, 1'b1);
        do_req(1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 32'h10, 3'b100, 32'h00000055, 32'h0, 1'b1);
        do_req(1'b1, 32'h00001010, 3'b010, 32'h01234567, 32'h0, 1'b1);
        do_req(1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);

        // Highest legal word
        do_req(1'b1, 32'hFFC, 3'b010, 32'h0A5A5A5A, 32'h0, 1'b0);
        do_req(1'b0, 32'hFFC, 3'b010, 32'h0, 32'h0A5A5A5A, 1'b0);

        // Streaming on the LATENCY=3 instance with req_valid held high
        last_acc = -1;
        n_acc    = 0;
        prev3    = 1'b0;
        @(negedge clk);
        bus3.req_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (bus3.rsp_valid) begin
                chk("s_pulse_width", 32'(prev3), 32'h0);
                chk("s_rdata", bus3.rsp_rdata, 32'h0);
                chk("s_error", 32'(bus3.rsp_error), 32'h0);
            end
            prev3 = bus3.rsp_valid;
            chk("s_busy", 32'(bus3.busy), 32'(!bus3.req_ready));
            if (bus3.req_ready) begin
                if (last_acc >= 0) chk("s_spacing", 32'(cyc + 1 - last_acc), 32'd4);
                last_acc = cyc + 1;
                n_acc++;
            end
            @(negedge clk);
        end
        bus3.req_valid = 1'b0;
        chk("s_accepts", 32'(n_acc), 32'd6);

        // Reset while a store waits: it must never land or respond
        do_req(1'b1, 32'h30, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h30;
        bus.req_func3 = 3'b010;
        bus.req_wdata = 32'h55555555;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.req_ready), 32'h1);
        chk("abort_busy_clr", 32'(bus.busy), 32'h0);
        chk("abort_valid", 32'(bus.rsp_valid), 32'h0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        do_req(1'b0, 32'h30, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
